// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the
// data-memory load/store unit.
package lsu_pkg;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_D  = 3'd4;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [2:0] MT_WU = 3'd7;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } lsu_state_t;

  // Returns 1 for any access that must trap: an unsupported size code, or a
  // supported size whose address is not naturally aligned.
  function automatic logic lsu_misaligned(input logic [1:0] off, input logic [2:0] typ);
    logic bad;
    case (typ)
      MT_B, MT_BU: bad = 1'b0;
      MT_H, MT_HU: bad = off[0];
      MT_W:        bad = |off;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic lsu_is_byte(input logic [2:0] typ);
    return (typ == MT_B) || (typ == MT_BU);
  endfunction

  function automatic logic lsu_is_half(input logic [2:0] typ);
    return (typ == MT_H) || (typ == MT_HU);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane steering: extracts and extends load data, and merges
// sub-word store data into a full word for the read-modify-write path.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_typ,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_byte   = i_word[8*i_off +: 8];
    w_half   = i_word[16*i_off[1] +: 16];
    o_load   = i_word;
    o_merged = i_word;

    case (i_typ)
      MT_B:    o_load = {{24{w_byte[7]}}, w_byte};
      MT_BU:   o_load = {24'd0, w_byte};
      MT_H:    o_load = {{16{w_half[15]}}, w_half};
      MT_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase

    // Only the low byte/half of the core store data is meaningful for sub-word stores.
    if (lsu_is_byte(i_typ)) begin
      o_merged[8*i_off +: 8] = i_sdata[7:0];
    end else if (lsu_is_half(i_typ)) begin
      o_merged[16*i_off[1] +: 16] = i_sdata[15:0];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a single-cycle core and a word-write-only
// scratchpad; one request in flight, sub-word stores done as read-modify-write.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          core_req_valid,
  output logic          core_req_ready,
  input  logic [AW-1:0] core_req_addr,
  input  logic [DW-1:0] core_req_data,
  input  logic          core_req_fcn,
  input  logic [2:0]    core_req_typ,
  output logic          core_resp_valid,
  output logic [DW-1:0] core_resp_data,
  output logic          core_resp_xcpt,

  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_data,
  output logic          mem_req_fcn,
  output logic [2:0]    mem_req_typ,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data
);

  lsu_state_t    r_state;
  lsu_state_t    w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_result;
  logic          r_fcn;
  logic [2:0]    r_typ;

  logic          w_accept;
  logic          w_rd_done;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_merged;

  lsu_lane u_lane (
    .i_word   (mem_resp_data),
    .i_off    (r_addr[1:0]),
    .i_typ    (r_typ),
    .i_sdata  (r_data),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign w_accept  = (r_state == IDLE) && core_req_valid && !rst;
  assign w_rd_done = (r_state == RD) && mem_req_valid && mem_req_ready && mem_resp_valid;

  always_comb begin
    w_next          = r_state;
    core_req_ready  = 1'b0;
    core_resp_valid = 1'b0;
    core_resp_xcpt  = 1'b0;
    core_resp_data  = '0;
    mem_req_valid   = 1'b0;
    mem_req_fcn     = M_XRD;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    mem_req_typ     = MT_X;

    case (r_state)
      IDLE: begin
        core_req_ready = 1'b1;
        if (core_req_valid) begin
          if (lsu_misaligned(core_req_addr[1:0], core_req_typ)) begin
            w_next = ERR;
          end else if (core_req_fcn == M_XWR && core_req_typ == MT_W) begin
            w_next = WR;
          end else begin
            w_next = RD;
          end
        end
      end
      RD: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready && mem_resp_valid) begin
          w_next = (r_fcn == M_XWR) ? WR : RESP;
        end
      end
      WR: begin
        mem_req_valid = 1'b1;
        mem_req_fcn   = M_XWR;
        mem_req_data  = r_wdata;
        if (mem_req_ready) begin
          w_next = RESP;
        end
      end
      RESP: begin
        core_resp_valid = 1'b1;
        core_resp_data  = r_result;
        w_next          = IDLE;
      end
      ERR: begin
        core_resp_valid = 1'b1;
        core_resp_xcpt  = 1'b1;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase

    if (mem_req_valid) begin
      mem_req_addr = {r_addr[AW-1:2], 2'b00};
      mem_req_typ  = MT_W;
    end

    // Reset silences every output at once, so an RMW cut off mid-flight never writes.
    if (rst) begin
      core_req_ready  = 1'b0;
      core_resp_valid = 1'b0;
      core_resp_xcpt  = 1'b0;
      core_resp_data  = '0;
      mem_req_valid   = 1'b0;
      mem_req_fcn     = M_XRD;
      mem_req_addr    = '0;
      mem_req_data    = '0;
      mem_req_typ     = MT_X;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_fcn    <= M_XRD;
      r_typ    <= MT_X;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= core_req_addr;
        r_data   <= core_req_data;
        r_wdata  <= core_req_data;
        r_fcn    <= core_req_fcn;
        r_typ    <= core_req_typ;
        r_result <= '0;
      end
      if (w_rd_done) begin
        if (r_fcn == M_XRD) begin
          r_result <= w_load;
        end else begin
          r_wdata <= w_merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a behavioural memory/ISA model predicts each
// core response and each scratchpad write; monitors compare as the DUT emits them.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_valid = 1'b0;
  logic        core_req_ready;
  logic [31:0] core_req_addr = '0;
  logic [31:0] core_req_data = '0;
  logic        core_req_fcn = 1'b0;
  logic [2:0]  core_req_typ = '0;
  logic        core_resp_valid;
  logic [31:0] core_resp_data;
  logic        core_resp_xcpt;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_fcn;
  logic [2:0]  mem_req_typ;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dmem_lsu #(.AW(32), .DW(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_addr   (core_req_addr),
    .core_req_data   (core_req_data),
    .core_req_fcn    (core_req_fcn),
    .core_req_typ    (core_req_typ),
    .core_resp_valid (core_resp_valid),
    .core_resp_data  (core_resp_data),
    .core_resp_xcpt  (core_resp_xcpt),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_fcn     (mem_req_fcn),
    .mem_req_typ     (mem_req_typ),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data)
  );

  // Scratchpad: 8 words at 0x100..0x11F, combinational read, full-word write.
  logic [31:0] smem [8];
  logic [31:0] ref_mem [8];
  assign mem_resp_valid = mem_req_valid && !mem_req_fcn;
  assign mem_resp_data  = smem[mem_req_addr[4:2]];
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_fcn && mem_req_ready) smem[mem_req_addr[4:2]] <= mem_req_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        xcpt;
    int          due;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_rd = 0, n_wr = 0, exp_rd = 0, exp_wr = 0;
  bit rand_ready = 1'b0;
  bit stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scratchpad ready is owned by this single process.
  initial forever begin
    @(posedge clk);
    #2;
    if (stall) mem_req_ready = 1'b0;
    else if (rand_ready) mem_req_ready = ($urandom_range(0, 3) != 0);
    else mem_req_ready = 1'b1;
  end

  always @(negedge clk) begin : monitor
    resp_t e;
    wr_t   w;
    if (core_resp_valid) begin
      check("resp_expected", resp_q.size() != 0, 1);
      if (resp_q.size() != 0) begin
        e = resp_q.pop_front();
        check("resp_data", core_resp_data, e.data);
        check("resp_xcpt", core_resp_xcpt, e.xcpt);
        if (e.due >= 0) check("resp_latency", cyc, e.due);
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_fcn) begin
        n_wr++;
        check("write_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("write_addr", mem_req_addr, w.addr);
          check("write_data", mem_req_data, w.data);
          check("write_typ", mem_req_typ, MT_W);
        end
      end else begin
        n_rd++;
      end
    end
  end

  // Architectural rules: legal sizes 1/2/4 bytes, naturally aligned.
  function automatic bit model_err(input logic [2:0] typ, input logic [31:0] addr);
    int sz;
    case (typ)
      3'd1, 3'd5: sz = 1;
      3'd2, 3'd6: sz = 2;
      3'd3:       sz = 4;
      default:    return 1'b1;
    endcase
    return (int'(addr[1:0]) % sz) != 0;
  endfunction

  // Issue one request; when track is set, the model predicts its outcome.
  // extra < 0 disables the latency check, otherwise it is added stall cycles.
  task automatic do_req(input bit fcn, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] data, input bit track, input int extra);
    int tries;
    int k, base, off, idx;
    logic [31:0] w, v, mask;
    resp_t e;
    wr_t wr;
    tries = 0;
    @(negedge clk);
    while (!core_req_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    check("req_ready_wait", tries < 200, 1);
    core_req_valid = 1'b1;
    core_req_fcn   = fcn;
    core_req_typ   = typ;
    core_req_addr  = addr;
    core_req_data  = data;
    @(posedge clk);
    k = cyc;
    #1 core_req_valid = 1'b0;
    if (!track) return;

    idx  = int'(addr[4:2]);
    off  = int'(addr[1:0]);
    w    = ref_mem[idx];
    e.xcpt = 1'b0;
    e.data = '0;
    if (model_err(typ, addr)) begin
      e.xcpt = 1'b1;
      base   = 1;
    end else if (!fcn) begin
      exp_rd++;
      base = 2;
      if (typ == 3'd1 || typ == 3'd5) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (typ == 3'd1 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (typ == 3'd2 || typ == 3'd6) begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (typ == 3'd2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      e.data = v;
    end else begin
      if (typ == 3'd3) begin
        v    = data;
        base = 2;
      end else begin
        exp_rd++;
        base = 3;
        if (typ == 3'd1 || typ == 3'd5) begin
          mask = 32'hFF << (8 * off);
          v    = (w & ~mask) | ((data & 32'hFF) << (8 * off));
        end else begin
          mask = 32'hFFFF << (16 * (off / 2));
          v    = (w & ~mask) | ((data & 32'hFFFF) << (16 * (off / 2)));
        end
      end
      ref_mem[idx] = v;
      wr.addr = {addr[31:2], 2'b00};
      wr.data = v;
      wr_q.push_back(wr);
      exp_wr++;
    end
    e.due = (extra < 0) ? -1 : k + base + extra;
    resp_q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (resp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_resp_queue", resp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      smem[i]   <= ref_mem[i];
    end
    ref_mem[0] = 32'h8877_6655;
    smem[0]   <= 32'h8877_6655;

    // Reset: all outputs low.
    @(negedge clk);
    check("rst_req_ready", core_req_ready, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_resp_valid", core_resp_valid, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", core_req_ready, 1);
    check("idle_resp_valid", core_resp_valid, 0);

    // Directed loads and byte-store RMW on word 0x100.
    do_req(M_XRD, MT_B,  32'h103, 32'h0, 1, 0);
    do_req(M_XRD, MT_BU, 32'h103, 32'h0, 1, 0);
    do_req(M_XRD, MT_HU, 32'h102, 32'h0, 1, 0);
    do_req(M_XWR, MT_B,  32'h101, 32'h0000_00AA, 1, 0);
    do_req(M_XRD, MT_W,  32'h100, 32'h0, 1, 0);
    do_req(M_XWR, MT_W,  32'h108, 32'hDEAD_BEEF, 1, 0);
    do_req(M_XRD, MT_H,  32'h10A, 32'h0, 1, 0);
    drain();
    check("word100_after_sb", smem[0], 32'h8877_AA55);

    // Traps: misaligned half/word and unsupported size touch no memory.
    rd0 = n_rd;
    wr0 = n_wr;
    do_req(M_XWR, MT_H,  32'h103, 32'h1234, 1, 0);
    do_req(M_XRD, MT_W,  32'h106, 32'h0, 1, 0);
    do_req(M_XRD, MT_D,  32'h100, 32'h0, 1, 0);
    do_req(M_XWR, MT_WU, 32'h104, 32'h5555, 1, 0);
    drain();
    check("err_no_reads", n_rd - rd0, 0);
    check("err_no_writes", n_wr - wr0, 0);

    // Scratchpad stalls the read phase of a halfword store for 3 cycles.
    rd0 = n_rd;
    wr0 = n_wr;
    stall = 1'b1;
    do_req(M_XWR, MT_H, 32'h102, 32'h1234_ABCD, 1, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", mem_req_valid, 1);
      check("stall_addr", mem_req_addr, 32'h100);
      check("stall_fcn", mem_req_fcn, M_XRD);
      @(posedge clk);
    end
    #1 stall = 1'b0;
    drain();
    check("stall_reads", n_rd - rd0, 1);
    check("stall_writes", n_wr - wr0, 1);

    // Reset lands in the write cycle of a byte store: no write, no response.
    do_req(M_XWR, MT_B, 32'h105, 32'h0000_00CC, 0, -1);
    exp_rd++;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstwr_mem_valid", mem_req_valid, 0);
    check("rstwr_resp_valid", core_resp_valid, 0);
    check("rstwr_req_ready", core_req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstwr_ready_after", core_req_ready, 1);
    check("rstwr_mem_intact", smem[1], ref_mem[1]);

    // Random traffic with random scratchpad back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h100 + 32'($urandom_range(0, 31)), $urandom, 1, -1);
    end
    rand_ready = 1'b0;
    drain();

    check("total_reads", n_rd, exp_rd);
    check("total_writes", n_wr, exp_wr);
    check("write_queue_empty", wr_q.size(), 0);
    for (int i = 0; i < 8; i++) check("final_mem", smem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
